// File: rtl/mult_ctrl_pkg.sv
// Shared types for the HI/LO multiply sequencer: request op-codes, sequencer
// states and the state encoding reported by the iterative multiplier core.
package mult_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MULT = 3'd1,
        OP_MTHI = 3'd2,
        OP_MTLO = 3'd3,
        OP_MFHI = 3'd4,
        OP_MFLO = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_LAUNCH,
        ST_WAIT,
        ST_CAPTURE
    } state_e;

    localparam logic [1:0] MUL_START = 2'd0;
    localparam logic [1:0] MUL_TEST  = 2'd1;
    localparam logic [1:0] MUL_DONE  = 2'd2;

endpackage

// File: rtl/hilo_mult_ctrl.sv
// Sequencer between the CPU control unit and the iterative signed multiplier
// core. Owns the architectural HI/LO registers, launches the core for MULT,
// captures its product, and stalls the requester while a multiply is in flight.
// The enclosing level ORs mul_clear with reset to form the core's reset.
module hilo_mult_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic [2:0]       op_code,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             op_ready,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             error,
    output logic             mul_clear,
    output logic             mul_enable,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    input  logic [1:0]       mul_state,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo
);

    // Sized so the timer can reach TIMEOUT; the abort at TIMEOUT means it never wraps.
    localparam int TW = $clog2(TIMEOUT + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             rd_valid_q, rd_valid_d;
    logic             error_q, error_d;
    logic             mul_clear_q, mul_clear_d;
    logic             mul_enable_q, mul_enable_d;

    // Next-state and next-output logic for the IDLE/CLEAR/LAUNCH/WAIT/CAPTURE sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        rd_data_d    = rd_data_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        timer_d      = timer_q;
        error_d      = error_q;
        rd_valid_d   = 1'b0;
        mul_clear_d  = 1'b0;
        mul_enable_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_e'(op_code))
                        OP_MULT: begin
                            mul_a_d     = rs_val;
                            mul_b_d     = rt_val;
                            error_d     = 1'b0;
                            mul_clear_d = 1'b1;
                            state_d     = ST_CLEAR;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_MFHI: begin
                            rd_data_d  = hi_q;
                            rd_valid_d = 1'b1;
                        end
                        OP_MFLO: begin
                            rd_data_d  = lo_q;
                            rd_valid_d = 1'b1;
                        end
                        default: ;  // NOP and the unused codes 6/7 do nothing
                    endcase
                end
            end
            ST_CLEAR: begin
                mul_enable_d = 1'b1;
                state_d      = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                timer_d      = '0;
                mul_enable_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // The timeout wins over a simultaneous DONE so a late core can never extend the wait.
                if (timer_q == TW'(TIMEOUT)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (mul_state == MUL_DONE) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        mul_enable_d = 1'b1;
                    end
                end
            end
            ST_CAPTURE: begin
                hi_d    = mul_hi;
                lo_d    = mul_lo;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset discards any in-flight multiply.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            hi_q         <= '0;
            lo_q         <= '0;
            rd_data_q    <= '0;
            mul_a_q      <= '0;
            mul_b_q      <= '0;
            timer_q      <= '0;
            rd_valid_q   <= 1'b0;
            error_q      <= 1'b0;
            mul_clear_q  <= 1'b0;
            mul_enable_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            rd_data_q    <= rd_data_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            timer_q      <= timer_d;
            rd_valid_q   <= rd_valid_d;
            error_q      <= error_d;
            mul_clear_q  <= mul_clear_d;
            mul_enable_q <= mul_enable_d;
        end
    end

    assign op_ready   = (state_q == ST_IDLE);
    assign stall      = op_valid & ~op_ready;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign error      = error_q;
    assign mul_clear  = mul_clear_q;
    assign mul_enable = mul_enable_q;
    assign mul_a      = mul_a_q;
    assign mul_b      = mul_b_q;

endmodule
